// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam int MAX_DIGITS = 8;

  // Active-low one-hot anode pattern; bits at or above n stay high.
  function automatic logic [MAX_DIGITS-1:0] an_onehot_n(input logic [2:0] idx, input int n);
    logic [MAX_DIGITS-1:0] r;
    r = '1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (idx == 3'(i))) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_7seg.sv
// Hex nibble to active-low segment pattern, bit 0 = segment a, bit 6 = segment g.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous data commit and PWM.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [DIV_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
  logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
  logic                    pend_full;
  logic                    slot_end, boundary, accept, lit;
  logic [3:0]              nibble;
  logic [SEG_W-1:0]        seg_hex;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [MAX_DIGITS-1:0]   an_full;

  assign load_ready = ~pend_full;
  assign accept     = load_valid && load_ready;
  assign slot_end   = enable && (pre == '1);
  assign boundary   = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (!enable) begin
        pre <= '0;
        idx <= '0;
      end else begin
        pre <= pre + 1'b1;
        if (boundary)      idx <= '0;
        else if (slot_end) idx <= idx + 1'b1;
      end
    end
  end

  // A disabled display has no frame to protect, so pending data commits immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
    end else if (accept && boundary) begin
      disp_data <= load_data;
      disp_dp   <= load_dp;
    end else if (accept) begin
      pend_data <= load_data;
      pend_dp   <= load_dp;
      pend_full <= 1'b1;
    end else if (pend_full && (boundary || !enable)) begin
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end
  end

  assign nibble = disp_data[{idx, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (nibble),
    .seg (seg_hex)
  );

`ifdef SEG7_LZB_EN
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run          = run && (disp_data[4*i +: 4] == 4'h0);
      lead_zero[i] = run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  assign lit     = enable && (pre[DIV_W-1 -: BRIGHT_W] <= brightness);
  assign an_full = an_onehot_n(3'(idx), NUM_DIGITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= an_full[NUM_DIGITS-1:0];
      seg <= lead_zero[idx] ? SEG_OFF : seg_hex;
      dp  <= ~disp_dp[idx];
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, DIV_W=4, BRIGHT_W=2); honours SEG7_LZB_EN.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BW = 2;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] ZL = 7'h7F;
`else
  localparam logic [6:0] ZL = 7'h40;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [BW-1:0] brightness = 2'd3;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [4*N-1:0] load_data = '0;
  logic [N-1:0]  load_dp = '0;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV_W(DW), .BRIGHT_W(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .brightness (brightness),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges since reset release.
  int cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         at;
    bit         is_lit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
    logic       tick;
    int         lit;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic push_pins(input string name, input int at, input logic [3:0] an_e,
                           input logic [6:0] seg_e, input logic dp_e, input logic rdy_e,
                           input logic tick_e);
    exp_t e;
    e.name = name; e.at = at; e.is_lit = 1'b0;
    e.an = an_e; e.seg = seg_e; e.dp = dp_e; e.rdy = rdy_e; e.tick = tick_e; e.lit = 0;
    sb.push_back(e);
  endtask

  task automatic push_lit(input string name, input int at, input int lit_e);
    exp_t e;
    e.name = name; e.at = at; e.is_lit = 1'b1;
    e.an = '1; e.seg = '1; e.dp = 1'b1; e.rdy = 1'b1; e.tick = 1'b0; e.lit = lit_e;
    sb.push_back(e);
  endtask

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int at, input logic v, input logic [15:0] d,
                                input logic [3:0] p);
    wait_cyc(at);
    load_valid = v;
    load_data  = d;
    load_dp    = p;
  endtask

  // Monitor: samples on the falling edge and retires every entry due this cycle.
  logic [15:0] lit_hist = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        lit_hist = {lit_hist[14:0], (an != 4'hF)};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
          e = sb.pop_front();
          if (e.at < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s missed: actual cyc=%0d required cyc=%0d", e.name, cyc, e.at);
          end else if (e.is_lit) begin
            check_output({e.name, "_lit"}, $countones(lit_hist), e.lit);
          end else begin
            check_output({e.name, "_an"},   int'(an),         int'(e.an));
            check_output({e.name, "_seg"},  int'(seg),        int'(e.seg));
            check_output({e.name, "_dp"},   int'(dp),         int'(e.dp));
            check_output({e.name, "_rdy"},  int'(load_ready), int'(e.rdy));
            check_output({e.name, "_tick"}, int'(frame_tick), int'(e.tick));
          end
        end
      end
    end
  end

  initial begin
    // Reset state and free-running scan before any load
    push_pins("A0_reset", 0,   4'hF, 7'h7F, 1, 1, 0);
    push_pins("A1_dig0",  5,   4'hE, 7'h40, 1, 1, 0);
    push_pins("A2_dig1",  20,  4'hD, ZL,    1, 1, 0);
    push_pins("A3_dig2",  40,  4'hB, ZL,    1, 1, 0);
    push_pins("A4_dig3",  60,  4'h7, ZL,    1, 1, 0);
    push_pins("A5_tick",  64,  4'h7, ZL,    1, 1, 1);
    push_pins("A6_wrap",  65,  4'hE, 7'h40, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Mid-frame load waits for the frame boundary
    wait_cyc(66);
    push_pins("B0_pend",  72,  4'hE, 7'h40, 1, 0, 0);
    push_pins("B1_old",   127, 4'h7, ZL,    1, 0, 0);
    push_pins("B2_cmt",   128, 4'h7, ZL,    1, 1, 1);
    push_pins("B3_d0",    129, 4'hE, 7'h19, 1, 1, 0);
    push_pins("B4_d1",    145, 4'hD, 7'h30, 1, 1, 0);
    push_pins("B5_d2dp",  161, 4'hB, 7'h24, 0, 1, 0);
    push_pins("B6_d3",    177, 4'h7, 7'h79, 1, 1, 0);
    apply_stimulus(70, 1'b1, 16'h1234, 4'b0100);
    apply_stimulus(71, 1'b0, 16'h1234, 4'b0100);

    // PWM duty: brightness 1 then 0
    wait_cyc(178);
    push_pins("C0_b1on",  193, 4'hE, 7'h19, 1, 1, 0);
    push_pins("C1_b1on",  200, 4'hE, 7'h19, 1, 1, 0);
    push_pins("C2_b1off", 201, 4'hF, 7'h7F, 1, 1, 0);
    push_lit ("C3_b1cnt", 224, 8);
    push_pins("C4_b0on",  228, 4'hB, 7'h24, 0, 1, 0);
    push_pins("C5_b0off", 229, 4'hF, 7'h7F, 1, 1, 0);
    push_lit ("C6_b0cnt", 240, 4);
    wait_cyc(192); brightness = 2'd1;
    wait_cyc(224); brightness = 2'd0;
    wait_cyc(240); brightness = 2'd3;

    // Accept on the boundary edge, then a stalled second load
    wait_cyc(241);
    push_pins("D0_bnd",   256, 4'h7, 7'h79, 1, 1, 1);
    push_pins("D1_d0",    257, 4'hE, 7'h21, 0, 1, 0);
    push_pins("D2_d1",    273, 4'hD, 7'h46, 1, 1, 0);
    push_pins("D3_stall", 300, 4'hB, 7'h03, 1, 0, 0);
    push_pins("D4_cmt",   320, 4'h7, 7'h08, 1, 1, 1);
    push_pins("D5_2nd",   321, 4'hE, 7'h00, 1, 0, 0);
    push_pins("D6_hold",  383, 4'h7, 7'h12, 1, 0, 0);
    push_pins("D7_cmt2",  385, 4'hE, 7'h79, 1, 1, 0);
    apply_stimulus(255, 1'b1, 16'hABCD, 4'b0001);
    apply_stimulus(256, 1'b0, 16'hABCD, 4'b0001);
    apply_stimulus(280, 1'b1, 16'h5678, 4'b0000);
    apply_stimulus(281, 1'b1, 16'h1111, 4'b0000);
    apply_stimulus(321, 1'b0, 16'h1111, 4'b0000);

    // Disable with pending data, then re-enable
    wait_cyc(386);
    push_pins("E0_pend",  405, 4'hD, 7'h79, 1, 0, 0);
    push_pins("E1_off",   411, 4'hF, 7'h7F, 1, 1, 0);
    push_pins("E2_off",   415, 4'hF, 7'h7F, 1, 1, 0);
    push_pins("E3_re0",   421, 4'hE, 7'h40, 1, 1, 0);
    push_pins("E4_re1",   437, 4'hD, 7'h40, 1, 1, 0);
    push_pins("E5_re2",   453, 4'hB, 7'h0E, 1, 1, 0);
    apply_stimulus(400, 1'b1, 16'h0F00, 4'b0000);
    apply_stimulus(401, 1'b0, 16'h0F00, 4'b0000);
    wait_cyc(410); enable = 1'b0;
    wait_cyc(420); enable = 1'b1;

    // Leading zeros: 0050 then 0000
    wait_cyc(454);
    push_pins("F0_pend",  470, 4'h7, ZL,    1, 0, 0);
    push_pins("F1_d0",    485, 4'hE, 7'h40, 1, 1, 0);
    push_pins("F2_d1",    501, 4'hD, 7'h12, 1, 1, 0);
    push_pins("F3_d2",    517, 4'hB, ZL,    1, 1, 0);
    push_pins("F4_d3",    533, 4'h7, ZL,    1, 1, 0);
    apply_stimulus(460, 1'b1, 16'h0050, 4'b0000);
    apply_stimulus(461, 1'b0, 16'h0050, 4'b0000);
    wait_cyc(534);
    push_pins("G0_pend",  545, 4'h7, ZL,    1, 0, 0);
    push_pins("G1_tick",  548, 4'h7, ZL,    1, 1, 1);
    push_pins("G2_d0",    549, 4'hE, 7'h40, 1, 1, 0);
    push_pins("G3_d1",    565, 4'hD, ZL,    1, 1, 0);
    push_pins("G4_d2",    581, 4'hB, ZL,    1, 1, 0);
    push_pins("G5_d3",    597, 4'h7, ZL,    1, 1, 0);
    apply_stimulus(540, 1'b1, 16'h0000, 4'b0000);
    apply_stimulus(541, 1'b0, 16'h0000, 4'b0000);

    wait_cyc(600);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
      failures += sb.size();
      checks++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
